// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one RAM port between an instruction and a data cache.
// Each transaction runs IDLE -> BUSY -> RESP, with a timeout that ends a stalled access with err.
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [9:0]  addr0,
    input  logic [9:0]  addr1,
    input  logic [19:0] wdata0,
    input  logic [19:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [19:0] rdata,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [9:0]  mem_addr,
    output logic [19:0] mem_wdata,
    input  logic [19:0] mem_rdata,
    input  logic        mem_ready
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          owner, ptr, rw_l, err_l, win;
    logic [9:0]    addr_l;
    logic [19:0]   wdata_l;
    logic [CW-1:0] cnt;

    // ptr remembers the last port served; on a tie the other port wins
    assign win = (req0 & req1) ? ~ptr : req1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            ptr     <= 1'b1;
            rw_l    <= 1'b0;
            err_l   <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            cnt     <= '0;
            rdata   <= '0;
        end else
            case (state)
                IDLE:
                    if (req0 | req1) begin
                        state   <= BUSY;
                        owner   <= win;
                        ptr     <= win;
                        rw_l    <= win ? rw1 : rw0;
                        addr_l  <= win ? addr1 : addr0;
                        wdata_l <= win ? wdata1 : wdata0;
                        cnt     <= '0;
                        err_l   <= 1'b0;
                    end
                BUSY:
                    if (mem_ready) begin
                        state <= RESP;
                        err_l <= 1'b0;
                        if (!rw_l) rdata <= mem_rdata;
                    end else if (cnt == LAST) begin
                        state <= RESP;
                        err_l <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase

    assign mem_en    = state == BUSY;
    assign gnt0      = (state != IDLE) & ~owner;
    assign gnt1      = (state != IDLE) & owner;
    assign done0     = (state == RESP) & ~owner;
    assign done1     = (state == RESP) & owner;
    assign err       = (state == RESP) & err_l;
    assign mem_rw    = mem_en & rw_l;
    assign mem_addr  = mem_en ? addr_l : '0;
    assign mem_wdata = mem_en ? wdata_l : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter, sampling outputs on the falling edge.
module tb_mem_arbiter;
    logic        clk = 0, rst = 1;
    logic        req0 = 0, req1 = 0, rw0 = 0, rw1 = 0;
    logic [9:0]  addr0 = 0, addr1 = 0;
    logic [19:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, done0, done1, err, mem_en, mem_rw, mem_ready = 0;
    logic [19:0] rdata, mem_wdata, mem_rdata = 0;
    logic [9:0]  mem_addr;
    int          checks = 0, fails = 0;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata(rdata), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // {gnt0,gnt1,done0,done1,err,mem_en}
    function automatic logic [5:0] ctl();
        return {gnt0, gnt1, done0, done1, err, mem_en};
    endfunction

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ctl(), mem_rw, mem_addr, mem_wdata, rdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h wdata=%h rdata=%h, want all 0", ctl(), mem_addr, mem_wdata, rdata);
        end
        rst = 0;
    endtask

    task automatic test_round_robin();
        req0 = 1; req1 = 1; rw0 = 0; rw1 = 0; addr0 = 10'd3; addr1 = 10'd9; mem_ready = 1; mem_rdata = 20'h00777;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({ctl(), mem_addr} !== {(i % 2 == 0) ? 6'b100001 : 6'b010001, (i % 2 == 0) ? 10'd3 : 10'd9}) begin
                fails++;
                $display("FAIL rr_busy[%0d]: got ctl=%b addr=%0d", i, ctl(), mem_addr);
            end
            @(negedge clk);
            checks++;
            if (ctl() !== ((i % 2 == 0) ? 6'b101000 : 6'b010100)) begin
                fails++;
                $display("FAIL rr_resp[%0d]: got ctl=%b", i, ctl());
            end
            if (i == 3) begin req0 = 0; req1 = 0; end
            @(negedge clk);
            checks++;
            if (ctl() !== 6'b000000) begin
                fails++;
                $display("FAIL rr_idle[%0d]: got ctl=%b, want 000000", i, ctl());
            end
        end
        mem_ready = 0;
    endtask

    task automatic test_read();
        req0 = 1; rw0 = 0; addr0 = 10'd50; mem_ready = 1; mem_rdata = 20'hABCDE;
        @(negedge clk);
        checks++;
        if ({ctl(), mem_rw, mem_addr} !== {6'b100001, 1'b0, 10'd50}) begin
            fails++;
            $display("FAIL read_busy: got ctl=%b rw=%b addr=%0d, want 100001 0 50", ctl(), mem_rw, mem_addr);
        end
        addr0 = 10'd7; rw0 = 1;
        @(negedge clk);
        checks++;
        if ({ctl(), mem_addr, rdata} !== {6'b101000, 10'd0, 20'hABCDE}) begin
            fails++;
            $display("FAIL read_resp: got ctl=%b addr=%0d rdata=%h, want 101000 0 abcde", ctl(), mem_addr, rdata);
        end
        req0 = 0; rw0 = 0; mem_ready = 0;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000) begin
            fails++;
            $display("FAIL read_idle: got ctl=%b, want 000000", ctl());
        end
    endtask

    task automatic test_write_wait();
        req1 = 1; rw1 = 1; addr1 = 10'd84; wdata1 = 20'h0012C; mem_rdata = 20'h55555;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({ctl(), mem_rw, mem_addr, mem_wdata} !== {6'b010001, 1'b1, 10'd84, 20'h0012C}) begin
                fails++;
                $display("FAIL write_busy[%0d]: got ctl=%b rw=%b addr=%0d wdata=%h", i, ctl(), mem_rw, mem_addr, mem_wdata);
            end
            req1 = 0; wdata1 = 20'hFFFFF;
            if (i == 3) mem_ready = 1;
        end
        @(negedge clk);
        checks++;
        if ({ctl(), mem_wdata, rdata} !== {6'b010100, 20'h0, 20'hABCDE}) begin
            fails++;
            $display("FAIL write_resp: got ctl=%b wdata=%h rdata=%h, want 010100 0 abcde", ctl(), mem_wdata, rdata);
        end
        mem_ready = 0;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000) begin
            fails++;
            $display("FAIL write_idle: got ctl=%b, want 000000", ctl());
        end
    endtask

    task automatic test_timeout();
        req0 = 1; rw0 = 0; addr0 = 10'd5; mem_rdata = 20'h11111; mem_ready = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 6'b100001) begin
                fails++;
                $display("FAIL timeout_busy[%0d]: got ctl=%b, want 100001", i, ctl());
            end
            req0 = 0;
        end
        @(negedge clk);
        checks++;
        if ({ctl(), rdata} !== {6'b101010, 20'hABCDE}) begin
            fails++;
            $display("FAIL timeout_resp: got ctl=%b rdata=%h, want 101010 abcde", ctl(), rdata);
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000) begin
            fails++;
            $display("FAIL timeout_idle: got ctl=%b, want 000000", ctl());
        end
    endtask

    task automatic test_reset_midflight();
        req1 = 1; rw1 = 0; addr1 = 10'd12; mem_ready = 0;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b010001) begin
            fails++;
            $display("FAIL mid_busy: got ctl=%b, want 010001", ctl());
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({ctl(), mem_rw, mem_addr, mem_wdata, rdata} !== '0) begin
            fails++;
            $display("FAIL async_reset: got ctl=%b addr=%h wdata=%h rdata=%h, want all 0", ctl(), mem_addr, mem_wdata, rdata);
        end
        @(negedge clk);
        rst = 0; req0 = 1; req1 = 1; mem_ready = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b100001) begin
            fails++;
            $display("FAIL post_reset_grant: got ctl=%b, want 100001", ctl());
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b101000) begin
            fails++;
            $display("FAIL post_reset_done: got ctl=%b, want 101000", ctl());
        end
        req0 = 0; req1 = 0; mem_ready = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read();
        test_write_wait();
        test_timeout();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
